mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter: RR, default 1; 1 selects round-robin tie-break, 0 selects fixed priority with port 1 winning.
REQ-002 Port: clk  in  1  single clock; all state updates on posedge clk.
REQ-003 Port: reset  in  1  synchronous, active-high reset.
REQ-004 Ports: p0_req, p1_req  in  1  access request, one per port (port 0 instruction fetch, port 1 data).
REQ-005 Ports: p0_we, p1_we  in  1  1 = write, 0 = read.
REQ-006 Ports: p0_addr, p1_addr  in  32  byte address, passed unmodified to memory.
REQ-007 Ports: p0_wdata, p1_wdata  in  32  write data.
REQ-008 Ports: p0_rdata, p1_rdata  out  32  registered read data, one register per port.
REQ-009 Ports: p0_ack, p1_ack  out  1  one-cycle completion pulse.
REQ-010 Ports: mem_write  out  1; mem_address  out  32; mem_write_data  out  32; mem_read_data  in  32; all connect to the shared asynchronous-read, clocked-write word memory.

Function
REQ-011 FSM states: IDLE, BUSY, DONE; reset state is IDLE.
REQ-012 IDLE: the FSM samples p0_req/p1_req only in this state; with no request it stays in IDLE.
REQ-013 IDLE, single request: latch the winner's index, we, addr and wdata, then go to BUSY.
REQ-014 IDLE, both requests with RR=1: grant the port not granted last; last_grant resets to 1, so port 0 wins the first tie.
REQ-015 IDLE, both requests with RR=0: grant port 1.
REQ-016 last_grant updates on every grant, including uncontended grants.
REQ-017 BUSY outputs: mem_address and mem_write_data carry the latched values, and mem_write equals the latched we for exactly this one cycle.
REQ-018 BUSY, read: mem_read_data loads into the winner's rdata register at the end of the cycle; the other port's rdata register holds.
REQ-019 BUSY, write: both rdata registers hold.
REQ-020 BUSY always goes to DONE.
REQ-021 DONE: the winner's ack is high for one cycle, and the FSM then goes to IDLE.
REQ-022 Latency: a request sampled in IDLE at cycle n produces ack at cycle n+2; throughput is at most one access per 3 cycles.
REQ-023 Requester protocol: hold req/we/addr/wdata until ack, then deassert req in the cycle after ack; the arbiter ignores input changes outside IDLE.
REQ-024 The losing port's request stays pending and, with RR=1, is granted on the next arbitration.
REQ-025 mem_write is 0 in IDLE and DONE.
REQ-026 mem_address and mem_write_data hold their last latched values outside BUSY.
REQ-027 p0_ack and p1_ack are never high together.
REQ-028 An ack is never issued without a preceding grant.

Reset
REQ-029 Reset values: state=IDLE, last_grant=1, mem_write=0, p0_ack=p1_ack=0, both rdata=0, mem_address=0, mem_write_data=0.
REQ-030 Reset asserted in BUSY or DONE aborts the access: no ack is issued and mem_write is 0 from the next edge.
REQ-031 After an aborted access the requester must re-request.
REQ-032 Reset overrides all other state updates in the same cycle.

Structure
REQ-033 Shared package contents: the state encoding constants (IDLE, BUSY, DONE) and the port index constants (PORT_IF=0, PORT_DM=1).
REQ-034 One sub-module, rr_pick2: combinational 2-way picker with inputs req[1:0], last and rr, and a one-hot grant output.
REQ-035 All remaining logic lives in mem_arbiter; target size is 120-250 RTL lines.

Verification
REQ-036 Single read: memory word 0x10 = 0xDEADBEEF, p0 reads addr 0x40 -> p0_ack at cycle +2, p0_rdata=0xDEADBEEF, p1 outputs unchanged.
REQ-037 Write then read: p1 writes 0x12345678 to addr 0x80 -> mem_write high exactly one cycle; a p0 read of 0x80 then returns 0x12345678.
REQ-038 Contention, RR=1: both ports request reads continuously after reset -> grant order p0, p1, p0, p1, and each ack is 3 cycles after the previous one.
REQ-039 Contention, RR=0: both ports request continuously -> p1 is granted every arbitration and p0 never receives ack.
REQ-040 Reset mid-BUSY: p1 write in flight, reset asserted in BUSY -> no p1_ack, the memory word is unchanged if reset precedes the BUSY edge, and all outputs are at reset values on the next cycle.
REQ-041 Input change after grant: p0_addr changes from 0x40 to 0x44 in BUSY -> the access still uses 0x40.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the two-port memory arbiter: FSM state encoding
// and the port index constants used to address the per-port signals.
package mem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic PORT_IF = 1'b0;  // instruction fetch
  localparam logic PORT_DM = 1'b1;  // data memory

endpackage

// File: rtl/rr_pick2.sv
// Combinational two-way picker. Returns a one-hot grant. A tie goes to the
// port not granted last in round-robin mode, and to port 1 otherwise.
module rr_pick2 (
  input  logic [1:0] req,
  input  logic       last,
  input  logic       rr,
  output logic [1:0] grant
);

  always_comb begin
    // NOTE: default assignment first so no path leaves grant unassigned (no latch).
    grant = 2'b00;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = (rr && last) ? 2'b01 : 2'b10;
      default: grant = 2'b00;
    endcase
  end

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates two requesters onto one async-read, clocked-write word memory.
// Each access takes IDLE -> BUSY -> DONE, so the ack arrives two cycles after the grant.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int RR = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        p0_req,
  input  logic        p0_we,
  input  logic [31:0] p0_addr,
  input  logic [31:0] p0_wdata,
  output logic [31:0] p0_rdata,
  output logic        p0_ack,
  input  logic        p1_req,
  input  logic        p1_we,
  input  logic [31:0] p1_addr,
  input  logic [31:0] p1_wdata,
  output logic [31:0] p1_rdata,
  output logic        p1_ack,
  output logic        mem_write,
  output logic [31:0] mem_address,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data
);

  localparam logic RR_EN = (RR != 0);

  state_t      state;
  logic        last_grant;
  logic        winner;
  logic        lat_we;
  logic [1:0]  grant;
  logic        win_sel;
  logic        win_we;
  logic [31:0] win_addr;
  logic [31:0] win_wdata;

  rr_pick2 u_pick (
    .req   ({p1_req, p0_req}),
    .last  (last_grant),
    .rr    (RR_EN),
    .grant (grant)
  );

  // Operands of whichever port the picker selected this cycle.
  always_comb begin
    win_sel   = grant[PORT_DM];
    win_we    = win_sel ? p1_we    : p0_we;
    win_addr  = win_sel ? p1_addr  : p0_addr;
    win_wdata = win_sel ? p1_wdata : p0_wdata;
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register
  // samples the values from before the edge regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      last_grant     <= PORT_DM;
      winner         <= PORT_IF;
      lat_we         <= 1'b0;
      mem_write      <= 1'b0;
      mem_address    <= '0;
      mem_write_data <= '0;
      p0_rdata       <= '0;
      p1_rdata       <= '0;
      p0_ack         <= 1'b0;
      p1_ack         <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          p0_ack    <= 1'b0;
          p1_ack    <= 1'b0;
          mem_write <= 1'b0;
          if (grant != 2'b00) begin
            winner         <= win_sel;
            last_grant     <= win_sel;
            lat_we         <= win_we;
            mem_address    <= win_addr;
            mem_write_data <= win_wdata;
            // mem_write is registered, so it is high exactly during BUSY.
            mem_write      <= win_we;
            state          <= BUSY;
          end
        end
        BUSY: begin
          mem_write <= 1'b0;
          if (!lat_we) begin
            if (winner == PORT_DM) p1_rdata <= mem_read_data;
            else                   p0_rdata <= mem_read_data;
          end
          p0_ack <= (winner == PORT_IF);
          p1_ack <= (winner == PORT_DM);
          state  <= DONE;
        end
        DONE: begin
          p0_ack <= 1'b0;
          p1_ack <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          mem_write <= 1'b0;
          p0_ack    <= 1'b0;
          p1_ack    <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter: a per-cycle vector table for single accesses,
// then hand-written sequences for contention, tie-break history and reset aborts.
module tb_mem_arbiter;

  logic        clk;
  logic        reset;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;

  // Round-robin instance and its memory
  logic [31:0] p0_rdata, p1_rdata, maddr, mwd, mrd;
  logic        p0_ack, p1_ack, mw;
  logic [31:0] mem [256];

  // Fixed-priority instance and its memory
  logic [31:0] fp_p0_rdata, fp_p1_rdata, fp_maddr, fp_mwd, fp_mrd;
  logic        fp_p0_ack, fp_p1_ack, fp_mw;
  logic [31:0] mem_fp [256];

  int n_vec = 0;
  int n_err = 0;

  mem_arbiter #(.RR(1)) dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(p0_rdata), .p0_ack(p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(p1_rdata), .p1_ack(p1_ack),
    .mem_write(mw), .mem_address(maddr), .mem_write_data(mwd), .mem_read_data(mrd)
  );

  mem_arbiter #(.RR(0)) dut_fp (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_rdata(fp_p0_rdata), .p0_ack(fp_p0_ack),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_rdata(fp_p1_rdata), .p1_ack(fp_p1_ack),
    .mem_write(fp_mw), .mem_address(fp_maddr), .mem_write_data(fp_mwd),
    .mem_read_data(fp_mrd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mrd    = mem[maddr[9:2]];
  assign fp_mrd = mem_fp[fp_maddr[9:2]];

  always @(posedge clk) begin
    if (mw)    mem[maddr[9:2]]       = mwd;
    if (fp_mw) mem_fp[fp_maddr[9:2]] = fp_mwd;
  end

  typedef struct {
    logic        rst;
    logic        r0, w0;
    logic [31:0] a0, d0;
    logic        r1, w1;
    logic [31:0] a1, d1;
    logic        e_ack0, e_ack1, e_mw;
    logic [31:0] e_addr, e_wdata, e_rd0, e_rd1;
  } vec_t;

  localparam int NV = 12;
  vec_t tbl [NV];

  function automatic vec_t mk(
    input logic rst, input logic r0, input logic w0, input logic [31:0] a0,
    input logic [31:0] d0, input logic r1, input logic w1, input logic [31:0] a1,
    input logic [31:0] d1, input logic e_ack0, input logic e_ack1, input logic e_mw,
    input logic [31:0] e_addr, input logic [31:0] e_wdata,
    input logic [31:0] e_rd0, input logic [31:0] e_rd1);
    vec_t v;
    v.rst = rst; v.r0 = r0; v.w0 = w0; v.a0 = a0; v.d0 = d0;
    v.r1 = r1; v.w1 = w1; v.a1 = a1; v.d1 = d1;
    v.e_ack0 = e_ack0; v.e_ack1 = e_ack1; v.e_mw = e_mw;
    v.e_addr = e_addr; v.e_wdata = e_wdata; v.e_rd0 = e_rd0; v.e_rd1 = e_rd1;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic r0, input logic w0, input logic [31:0] a0,
                       input logic [31:0] d0, input logic r1, input logic w1,
                       input logic [31:0] a1, input logic [31:0] d1);
    p0_req = r0; p0_we = w0; p0_addr = a0; p0_wdata = d0;
    p1_req = r1; p1_we = w1; p1_addr = a1; p1_wdata = d1;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      mem_fp[i] = 32'h0;
    end
    mem[8'h10] = 32'hDEADBEEF;  mem_fp[8'h10] = 32'hDEADBEEF;
    mem[8'h11] = 32'hCAFEF00D;  mem_fp[8'h11] = 32'hCAFEF00D;
    mem[8'h31] = 32'h31313131;  mem_fp[8'h31] = 32'h31313131;

    reset = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0);

    // Expected columns are the outputs just after the edge that consumes the inputs.
    //            rst r0 w0 a0          d0  r1 w1 a1          d1            ack0 ack1 mw addr        wdata         rd0           rd1
    tbl[0]  = mk(1, 0, 0, 32'h0,  0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        32'h0,        32'h0);
    tbl[1]  = mk(0, 0, 0, 32'h0,  0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h0,  32'h0,        32'h0,        32'h0);
    tbl[2]  = mk(0, 1, 0, 32'h40, 0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h40, 32'h0,        32'h0,        32'h0);
    tbl[3]  = mk(0, 1, 0, 32'h44, 0,  0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h40, 32'h0,        32'hDEADBEEF, 32'h0);
    tbl[4]  = mk(0, 1, 0, 32'h44, 0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h40, 32'h0,        32'hDEADBEEF, 32'h0);
    tbl[5]  = mk(0, 0, 0, 32'h0,  0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h40, 32'h0,        32'hDEADBEEF, 32'h0);
    tbl[6]  = mk(0, 0, 0, 32'h0,  0,  1, 1, 32'h80, 32'h12345678, 0, 0, 1, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[7]  = mk(0, 0, 0, 32'h0,  0,  1, 1, 32'h80, 32'h12345678, 0, 1, 0, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[8]  = mk(0, 0, 0, 32'h0,  0,  1, 1, 32'h80, 32'h12345678, 0, 0, 0, 32'h80, 32'h12345678, 32'hDEADBEEF, 32'h0);
    tbl[9]  = mk(0, 1, 0, 32'h80, 0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h80, 32'h0,        32'hDEADBEEF, 32'h0);
    tbl[10] = mk(0, 1, 0, 32'h80, 0,  0, 0, 32'h0,  32'h0,        1, 0, 0, 32'h80, 32'h0,        32'h12345678, 32'h0);
    tbl[11] = mk(0, 1, 0, 32'h80, 0,  0, 0, 32'h0,  32'h0,        0, 0, 0, 32'h80, 32'h0,        32'h12345678, 32'h0);

    #2;
    for (int i = 0; i < NV; i++) begin
      reset = tbl[i].rst;
      drive(tbl[i].r0, tbl[i].w0, tbl[i].a0, tbl[i].d0,
            tbl[i].r1, tbl[i].w1, tbl[i].a1, tbl[i].d1);
      step();
      check($sformatf("vec%0d_p0_ack", i), 32'(p0_ack), 32'(tbl[i].e_ack0));
      check($sformatf("vec%0d_p1_ack", i), 32'(p1_ack), 32'(tbl[i].e_ack1));
      check($sformatf("vec%0d_mem_write", i), 32'(mw), 32'(tbl[i].e_mw));
      check($sformatf("vec%0d_mem_address", i), maddr, tbl[i].e_addr);
      check($sformatf("vec%0d_mem_write_data", i), mwd, tbl[i].e_wdata);
      check($sformatf("vec%0d_p0_rdata", i), p0_rdata, tbl[i].e_rd0);
      check($sformatf("vec%0d_p1_rdata", i), p1_rdata, tbl[i].e_rd1);
    end
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    check("write_landed", mem[8'h20], 32'h12345678);

    // An uncontended p0 grant must count as history: the next tie goes to p1.
    reset = 1'b1; step(); reset = 1'b0;
    drive(1, 0, 32'h40, 0, 0, 0, 0, 0);
    step(); step(); step();
    drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
    step(); step();
    check("hist_p1_ack", 32'(p1_ack), 32'd1);
    check("hist_p0_ack", 32'(p0_ack), 32'd0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    step();

    // Continuous contention from reset: RR alternates p0,p1; fixed priority starves p0.
    reset = 1'b1; step(); reset = 1'b0;
    drive(1, 0, 32'h40, 0, 1, 0, 32'h44, 0);
    for (int c = 1; c <= 12; c++) begin
      step();
      check($sformatf("rr_c%0d_p0_ack", c), 32'(p0_ack), 32'(c == 2 || c == 8));
      check($sformatf("rr_c%0d_p1_ack", c), 32'(p1_ack), 32'(c == 5 || c == 11));
      check($sformatf("fp_c%0d_p0_ack", c), 32'(fp_p0_ack), 32'd0);
      check($sformatf("fp_c%0d_p1_ack", c), 32'(fp_p1_ack), 32'(c == 2 || c == 5 || c == 8 || c == 11));
    end
    check("rr_p0_rdata", p0_rdata, 32'hDEADBEEF);
    check("rr_p1_rdata", p1_rdata, 32'hCAFEF00D);
    check("fp_p0_rdata", fp_p0_rdata, 32'h0);
    check("fp_p1_rdata", fp_p1_rdata, 32'hCAFEF00D);

    // Reset while a p1 write is in BUSY: no ack, outputs back to reset values.
    drive(0, 0, 0, 0, 1, 1, 32'hC0, 32'hAAAA5555);
    step();
    check("abort_busy_mw", 32'(mw), 32'd1);
    reset = 1'b1;
    step();
    check("abort_mw", 32'(mw), 32'd0);
    check("abort_p1_ack", 32'(p1_ack), 32'd0);
    check("abort_addr", maddr, 32'h0);
    check("abort_wdata", mwd, 32'h0);
    check("abort_p0_rdata", p0_rdata, 32'h0);
    check("abort_p1_rdata", p1_rdata, 32'h0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 4; c++) begin
      step();
      check($sformatf("abort_after%0d_p1_ack", c), 32'(p1_ack), 32'd0);
      check($sformatf("abort_after%0d_mw", c), 32'(mw), 32'd0);
    end

    // Reset on the grant edge: the write never starts and memory is untouched.
    drive(0, 0, 0, 0, 1, 1, 32'hC4, 32'h55AA55AA);
    reset = 1'b1;
    step();
    check("pre_busy_mw", 32'(mw), 32'd0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    for (int c = 0; c < 3; c++) begin
      step();
      check($sformatf("pre_busy%0d_p1_ack", c), 32'(p1_ack), 32'd0);
    end
    check("pre_busy_mem", mem[8'h31], 32'h31313131);
    check("pre_busy_fp_addr", fp_maddr, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  // Acks must never coincide.
  always @(negedge clk) begin
    if (p0_ack && p1_ack) begin
      n_vec++;
      n_err++;
      $display("FAIL both_acks: got p0_ack=1 p1_ack=1 expected at most one");
    end
  end

endmodule
